// File: rtl/decode_prefix_sequencer.sv
// decode_prefix_sequencer
// Gathers the prefix bytes of one instruction, which may be spread over
// several fetch windows, into a single summary for the opcode stage.
// Retires the prefix bytes from the fetch queue as they are consumed and
// holds the summary until the opcode stage accepts it.
// Optional feature: define PREFIX_SEQ_LENGTH_CHECK_EN to fault on prefix runs
// of 15 bytes or more. The fault is held until flush or reset.
module decode_prefix_sequencer (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic       i_flush,
    input  logic [2:0] i_queue_valid_count,
    input  logic [2:0] i_prefix_count,
    input  logic       i_lock,
    input  logic       i_repeat_ne,
    input  logic       i_repeat_e,
    input  logic       i_operand_size,
    input  logic       i_address_size,
    input  logic       i_segment_override,
    input  logic [2:0] i_segment_override_index,
    input  logic       i_prefix_error,
    input  logic       i_prefix_ready,
    output logic [2:0] o_queue_pop,
    output logic       o_prefix_valid,
    output logic       o_lock,
    output logic       o_repeat_ne,
    output logic       o_repeat_e,
    output logic       o_operand_size,
    output logic       o_address_size,
    output logic       o_segment_override,
    output logic [2:0] o_segment_override_index,
    output logic [3:0] o_prefix_bytes,
    output logic       o_error,
    output logic       o_fault
);

`ifdef PREFIX_SEQ_LENGTH_CHECK_EN
    typedef enum logic [1:0] {
        ST_SCAN  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_SCAN  = 2'd0,
        ST_HOLD  = 2'd1
    } state_t;
`endif

    // Everything the opcode stage sees about the prefix run, cleared as a unit
    typedef struct packed {
        logic       lock;
        logic       repeat_ne;
        logic       repeat_e;
        logic       operand_size;
        logic       address_size;
        logic       seg_override;
        logic [2:0] seg_index;
        logic [3:0] bytes;
        logic       error;
    } summary_t;

    state_t     r_state;
    summary_t   r_sum;
    logic       r_prefix_valid;
    logic       r_fault;

    logic [2:0] w_valid_clamped;
    logic [2:0] w_eff;
    logic       w_scan;
    logic       w_take;
    logic       w_accum;
    logic       w_opcode_seen;
    logic [4:0] w_bytes_sum;
    logic [3:0] w_bytes_next;

    // Window decode: effective prefix count and what this SCAN cycle does
    always_comb begin
        w_valid_clamped = (i_queue_valid_count > 3'd4) ? 3'd4 : i_queue_valid_count;
        w_eff           = (i_prefix_count < w_valid_clamped) ? i_prefix_count : w_valid_clamped;
        w_scan          = (r_state == ST_SCAN);
        w_take          = w_scan && !i_flush && (w_valid_clamped != 3'd0);
        w_accum         = w_take && (w_eff != 3'd0);
        w_opcode_seen   = w_take && (w_eff < w_valid_clamped);
        w_bytes_sum     = {1'b0, r_sum.bytes} + {2'b00, w_eff};
        w_bytes_next    = (w_bytes_sum > 5'd15) ? 4'd15 : w_bytes_sum[3:0];
    end

    // Queue pop is combinational and must read 0 while reset is held
    always_comb begin
        o_queue_pop = '0;
        if (i_reset_n && w_scan && !i_flush) begin
            o_queue_pop = w_eff;
        end
    end

    // Sequencer: accumulate in SCAN, present in HOLD, park in FAULT
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state        <= ST_SCAN;
            r_sum          <= '0;
            r_prefix_valid <= 1'b0;
            r_fault        <= 1'b0;
        end else if (i_flush) begin
            r_state        <= ST_SCAN;
            r_sum          <= '0;
            r_prefix_valid <= 1'b0;
            r_fault        <= 1'b0;
        end else begin
            case (r_state)
                ST_SCAN: begin
                    if (w_accum) begin
                        r_sum.lock         <= r_sum.lock         | i_lock;
                        r_sum.repeat_ne    <= r_sum.repeat_ne    | i_repeat_ne;
                        r_sum.repeat_e     <= r_sum.repeat_e     | i_repeat_e;
                        r_sum.operand_size <= r_sum.operand_size | i_operand_size;
                        r_sum.address_size <= r_sum.address_size | i_address_size;
                        r_sum.seg_override <= r_sum.seg_override | i_segment_override;
                        r_sum.error        <= r_sum.error        | i_prefix_error;
                        r_sum.bytes        <= w_bytes_next;
                        if (i_segment_override) begin
                            r_sum.seg_index <= i_segment_override_index;
                        end
                    end
`ifdef PREFIX_SEQ_LENGTH_CHECK_EN
                    // Overlong run wins over a same-cycle opcode detection
                    if (w_accum && (w_bytes_next > 4'd14)) begin
                        r_state <= ST_FAULT;
                        r_fault <= 1'b1;
                    end else if (w_opcode_seen) begin
                        r_state        <= ST_HOLD;
                        r_prefix_valid <= 1'b1;
                    end
`else
                    if (w_opcode_seen) begin
                        r_state        <= ST_HOLD;
                        r_prefix_valid <= 1'b1;
                    end
`endif
                end
                ST_HOLD: begin
                    if (i_prefix_ready) begin
                        r_state        <= ST_SCAN;
                        r_sum          <= '0;
                        r_prefix_valid <= 1'b0;
                    end
                end
`ifdef PREFIX_SEQ_LENGTH_CHECK_EN
                ST_FAULT: begin
                    r_fault <= 1'b1;
                end
`endif
                default: begin
                    r_state        <= ST_SCAN;
                    r_sum          <= '0;
                    r_prefix_valid <= 1'b0;
                    r_fault        <= 1'b0;
                end
            endcase
        end
    end

    // Flush suppresses the summary in the cycle it is asserted
    assign o_prefix_valid           = r_prefix_valid & ~i_flush;
    assign o_lock                   = r_sum.lock;
    assign o_repeat_ne              = r_sum.repeat_ne;
    assign o_repeat_e               = r_sum.repeat_e;
    assign o_operand_size           = r_sum.operand_size;
    assign o_address_size           = r_sum.address_size;
    assign o_segment_override       = r_sum.seg_override;
    assign o_segment_override_index = r_sum.seg_index;
    assign o_prefix_bytes           = r_sum.bytes;
    assign o_error                  = r_sum.error;
    assign o_fault                  = r_fault;

endmodule

// File: tb/tb_decode_prefix_sequencer.sv
// Self-checking bench for decode_prefix_sequencer: directed scenarios with
// literal expectations plus randomized windows against a behavioural model.
module tb_decode_prefix_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [2:0] qv = '0;
    logic [2:0] pc = '0;
    logic       lock = 1'b0, rne = 1'b0, re = 1'b0, opsz = 1'b0, adsz = 1'b0, seg = 1'b0;
    logic [2:0] segi = '0;
    logic       perr = 1'b0;
    logic       ready = 1'b0;

    logic [2:0] o_pop;
    logic       o_valid;
    logic       o_lock, o_rne, o_re, o_opsz, o_adsz, o_seg;
    logic [2:0] o_segi;
    logic [3:0] o_bytes;
    logic       o_err, o_fault;

    decode_prefix_sequencer dut (
        .i_clock                  (clk),
        .i_reset_n                (rst_n),
        .i_flush                  (flush),
        .i_queue_valid_count      (qv),
        .i_prefix_count           (pc),
        .i_lock                   (lock),
        .i_repeat_ne              (rne),
        .i_repeat_e               (re),
        .i_operand_size           (opsz),
        .i_address_size           (adsz),
        .i_segment_override       (seg),
        .i_segment_override_index (segi),
        .i_prefix_error           (perr),
        .i_prefix_ready           (ready),
        .o_queue_pop              (o_pop),
        .o_prefix_valid           (o_valid),
        .o_lock                   (o_lock),
        .o_repeat_ne              (o_rne),
        .o_repeat_e               (o_re),
        .o_operand_size           (o_opsz),
        .o_address_size           (o_adsz),
        .o_segment_override       (o_seg),
        .o_segment_override_index (o_segi),
        .o_prefix_bytes           (o_bytes),
        .o_error                  (o_err),
        .o_fault                  (o_fault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: phase of the instruction plus the accumulated summary
    localparam int P_SCAN  = 0;
    localparam int P_HOLD  = 1;
    localparam int P_FAULT = 2;
    int       m_phase;
    bit [5:0] m_flags;   // lock, rne, re, opsz, adsz, seg
    int       m_idx;
    int       m_bytes;
    bit       m_err;

    function automatic int win_valid();
        return (int'(qv) > 4) ? 4 : int'(qv);
    endfunction

    function automatic int win_eff();
        int v;
        v = win_valid();
        return (int'(pc) < v) ? int'(pc) : v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_phase = P_SCAN;
        m_flags = '0;
        m_idx   = 0;
        m_bytes = 0;
        m_err   = 1'b0;
    endtask

    task automatic model_step();
        int v, e;
        v = win_valid();
        e = win_eff();
        if (!rst_n || flush) begin
            model_reset();
        end else if (m_phase == P_SCAN) begin
            if (v > 0) begin
                if (e > 0) begin
                    m_flags = m_flags | {lock, rne, re, opsz, adsz, seg};
                    if (seg) m_idx = int'(segi);
                    m_err   = m_err | perr;
                    m_bytes = (m_bytes + e > 15) ? 15 : m_bytes + e;
                end
`ifdef PREFIX_SEQ_LENGTH_CHECK_EN
                if (m_bytes > 14) m_phase = P_FAULT;
                else if (e < v) m_phase = P_HOLD;
`else
                if (e < v) m_phase = P_HOLD;
`endif
            end
        end else if (m_phase == P_HOLD && ready) begin
            model_reset();
        end
    endtask

    task automatic check_model();
        chk("pop",     int'(o_pop),   (rst_n && !flush && m_phase == P_SCAN) ? win_eff() : 0);
        chk("valid",   int'(o_valid), (m_phase == P_HOLD && !flush) ? 1 : 0);
        chk("fault",   int'(o_fault), (m_phase == P_FAULT) ? 1 : 0);
        chk("lock",    int'(o_lock),  int'(m_flags[5]));
        chk("rep_ne",  int'(o_rne),   int'(m_flags[4]));
        chk("rep_e",   int'(o_re),    int'(m_flags[3]));
        chk("opsize",  int'(o_opsz),  int'(m_flags[2]));
        chk("adsize",  int'(o_adsz),  int'(m_flags[1]));
        chk("segov",   int'(o_seg),   int'(m_flags[0]));
        chk("seg_idx", int'(o_segi),  m_idx);
        chk("bytes",   int'(o_bytes), m_bytes);
        chk("error",   int'(o_err),   int'(m_err));
    endtask

    // One clock: compare mid-cycle, then advance the model at the edge
    task automatic cyc();
        @(negedge clk);
        check_model();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        flush = 1'b0; qv = '0; pc = '0;
        {lock, rne, re, opsz, adsz, seg} = '0;
        segi = '0; perr = 1'b0; ready = 1'b0;
    endtask

    task automatic win(input int v, input int c, input bit [5:0] fl, input int idx);
        idle();
        qv = 3'(v);
        pc = 3'(c);
        {lock, rne, re, opsz, adsz, seg} = fl;
        segi = 3'(idx);
    endtask

    initial begin
        model_reset();
        // Reset with live-looking inputs: everything must read 0
        rst_n = 1'b0;
        win(4, 3, 6'b100001, 5);
        #2;
        chk("rst_pop",   int'(o_pop), 0);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_bytes", int'(o_bytes), 0);
        chk("rst_fault", int'(o_fault), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle();

        // Two prefixes then opcode; summary one cycle later, cleared on ready
        #2; chk("idle_pop", int'(o_pop), 0);
        cyc();
        win(4, 2, 6'b000110, 0);
        #2; chk("t1_pop", int'(o_pop), 2);
        cyc();
        idle(); ready = 1'b1;
        #2;
        chk("t1_valid", int'(o_valid), 1);
        chk("t1_opsz",  int'(o_opsz), 1);
        chk("t1_adsz",  int'(o_adsz), 1);
        chk("t1_bytes", int'(o_bytes), 2);
        chk("t1_hpop",  int'(o_pop), 0);
        cyc();
        idle();
        #2;
        chk("t1_clr_valid", int'(o_valid), 0);
        chk("t1_clr_bytes", int'(o_bytes), 0);
        chk("t1_clr_opsz",  int'(o_opsz), 0);
        cyc();

        // Sixteen prefix bytes in four full windows
        for (int k = 0; k < 4; k++) begin
            win(4, 4, 6'b001111, 1);
            #2;
`ifdef PREFIX_SEQ_LENGTH_CHECK_EN
            if (k < 3) chk("long_pop", int'(o_pop), 4);
`else
            chk("long_pop", int'(o_pop), 4);
`endif
            cyc();
        end
        win(1, 0, 6'b000000, 0);
`ifdef PREFIX_SEQ_LENGTH_CHECK_EN
        #2;
        chk("long_fault",    int'(o_fault), 1);
        chk("long_fpop",     int'(o_pop), 0);
        chk("long_fvalid",   int'(o_valid), 0);
        cyc();
        idle(); flush = 1'b1;
        #2; chk("long_flush_pop", int'(o_pop), 0);
        cyc();
        idle();
        #2;
        chk("long_clr_fault", int'(o_fault), 0);
        chk("long_clr_bytes", int'(o_bytes), 0);
        chk("long_clr_re",    int'(o_re), 0);
        cyc();
`else
        #2;
        chk("long_opc_pop", int'(o_pop), 0);
        cyc();
        idle(); ready = 1'b1;
        #2;
        chk("long_bytes", int'(o_bytes), 15);
        chk("long_valid", int'(o_valid), 1);
        chk("long_fault", int'(o_fault), 0);
        cyc();
        idle();
        cyc();
`endif

        // Segment override: last one wins
        win(1, 1, 6'b000001, 1);
        cyc();
        win(2, 1, 6'b000001, 0);
        cyc();
        idle(); ready = 1'b1;
        #2;
        chk("seg_idx_last", int'(o_segi), 0);
        chk("seg_flag",     int'(o_seg), 1);
        chk("seg_valid",    int'(o_valid), 1);
        chk("seg_bytes",    int'(o_bytes), 2);
        cyc();
        idle();
        cyc();

        // Flush and ready together in HOLD
        win(2, 1, 6'b100000, 0);
        cyc();
        idle(); flush = 1'b1; ready = 1'b1;
        #2;
        chk("fr_pop",   int'(o_pop), 0);
        chk("fr_valid", int'(o_valid), 0);
        cyc();
        idle();
        #2;
        chk("fr_next_valid", int'(o_valid), 0);
        chk("fr_next_lock",  int'(o_lock), 0);
        chk("fr_next_bytes", int'(o_bytes), 0);
        cyc();

        // Asynchronous reset mid-sequence
        win(3, 3, 6'b101000, 0);
        #2; chk("ar_pop3", int'(o_pop), 3);
        cyc();
        win(4, 2, 6'b000100, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_pop",   int'(o_pop), 0);
        chk("ar_lock",  int'(o_lock), 0);
        chk("ar_re",    int'(o_re), 0);
        chk("ar_bytes", int'(o_bytes), 0);
        chk("ar_valid", int'(o_valid), 0);
        model_reset();
        cyc();
        rst_n = 1'b1;
        idle();
        #2; chk("ar_first_pop", int'(o_pop), 0);
        cyc();

        // Randomized windows
        for (int n = 0; n < 3000; n++) begin
            qv    = 3'($urandom_range(0, 7));
            pc    = 3'($urandom_range(0, 4));
            {lock, rne, re, opsz, adsz, seg} = 6'($urandom);
            segi  = 3'($urandom);
            perr  = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 15) == 0);
            ready = 1'($urandom);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_prefix_sequencer.md
DECODE_PREFIX_SEQUENCER -- requirements
Module: decode_prefix_sequencer

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset; i_clock and i_reset_n are its only clock and reset ports.
REQ-002 i_clock  input  1  rising-edge clock for all state.
REQ-003 i_reset_n  input  1  asynchronous active-low reset.
REQ-004 i_flush  input  1  discard the in-progress prefix sequence.
REQ-005 i_queue_valid_count  input  3  valid bytes in the 4-byte fetch window, 0..4; values above 4 are treated as 4.
REQ-006 i_prefix_count  input  3  leading prefix bytes in the window, as reported by the prefix decoder, 0..4.
REQ-007 i_lock, i_repeat_ne, i_repeat_e, i_operand_size, i_address_size, i_segment_override  input  1 each  per-window prefix flags.
REQ-008 i_segment_override_index  input  3  segment for the window's override.
REQ-009 i_prefix_error  input  1  decoder reports duplicate-group error in the window.
REQ-010 i_prefix_ready  input  1  opcode stage accepts the prefix summary.
REQ-011 o_queue_pop  output  3  bytes to retire from the fetch queue this cycle, 0..4.
REQ-012 o_prefix_valid  output  1  prefix summary valid; an opcode byte sits at window index 0 after the pop.
REQ-013 o_lock, o_repeat_ne, o_repeat_e, o_operand_size, o_address_size, o_segment_override  output  1 each  accumulated flags.
REQ-014 o_segment_override_index  output  3  accumulated segment index.
REQ-015 o_prefix_bytes  output  4  total prefix bytes consumed, saturating at 15.
REQ-016 o_error  output  1  sticky OR of i_prefix_error over the sequence.
REQ-017 o_fault  output  1  prefix-length fault.

Function
REQ-018 The block SHALL implement the states SCAN, HOLD and FAULT.
REQ-019 eff = min(i_prefix_count, i_queue_valid_count), where i_queue_valid_count is first clamped to 4.
REQ-020 SCAN, valid=0: o_queue_pop=0 and no state change.
REQ-021 SCAN, eff==valid>0 (whole window is prefixes): o_queue_pop=eff, flags accumulated, o_prefix_bytes += eff, remain in SCAN.
REQ-022 SCAN, eff<valid (opcode at index eff): o_queue_pop=eff, flags accumulated, o_prefix_bytes += eff, go to HOLD on the next edge.
REQ-023 Accumulation SHALL apply as follows:
- lock, repeat_ne, repeat_e, operand_size, address_size, segment_override: ORed into the registers.
- o_segment_override_index: takes the new value only when i_segment_override=1 and eff>0.
- o_error |= i_prefix_error, but only when eff>0.
REQ-024 Input flags SHALL be ignored when eff=0.
REQ-025 HOLD: o_prefix_valid=1, o_queue_pop=0, and all summary outputs are held stable.
REQ-026 HOLD, on i_prefix_ready=1: clear all accumulators and o_prefix_bytes on that edge and return to SCAN; the next window is not examined until the following cycle.
REQ-027 o_prefix_valid SHALL be a registered output, and SHALL be asserted exactly in HOLD.
REQ-028 Latency: the summary becomes valid one cycle after the opcode-detecting SCAN cycle, and zero-prefix instructions also pass through HOLD.
REQ-029 o_queue_pop SHALL be combinational from the state and inputs, and SHALL be 0 outside SCAN.
REQ-030 i_flush=1 in any state SHALL force o_queue_pop=0 and o_prefix_valid=0 that cycle, clear all accumulators, and enter SCAN; flush has priority over i_prefix_ready and over the fault logic.
REQ-031 o_prefix_bytes SHALL saturate at 15 and never wrap.

Reset
REQ-032 While i_reset_n=0 the block SHALL be in state SCAN and drive the following values:
- o_prefix_valid=0, o_queue_pop=0.
- All flags=0, o_segment_override_index=0.
- o_prefix_bytes=0, o_error=0, o_fault=0.
REQ-033 Reset asserted mid-sequence SHALL discard the partial accumulation immediately, without waiting for a clock edge.

Configuration
REQ-034 Macro PREFIX_SEQ_LENGTH_CHECK_EN defined, length fault enabled:
- A SCAN update that makes o_prefix_bytes exceed 14 enters FAULT.
- FAULT drives o_fault=1, o_queue_pop=0 and o_prefix_valid=0.
- FAULT is left only by i_flush or reset.
REQ-035 Macro undefined: the FAULT state is absent, o_fault is tied 0, and sequences of any length continue with o_prefix_bytes saturated at 15.

Verification
REQ-036 Window {66,67,8B,xx}, valid=4, count=2 -> pop=2. Next cycle valid=1, operand_size=1, address_size=1, prefix_bytes=2. Ready=1 -> next cycle valid=0, all cleared.
REQ-037 Four windows of 4 prefixes each (F3/2E/66/67 repeated), then {opcode}; macro defined -> pops 4,4,4, then the bytes=16 update enters FAULT, o_fault=1 and pop=0. Flush -> SCAN, all outputs cleared.
REQ-038 The REQ-037 stimulus with the macro undefined -> o_fault stays 0, pops 4,4,4,4, then prefix_bytes=15 saturated and valid=1.
REQ-039 Window {2E,...} with index 1, then next window {26,...} with index 0 and opcode following -> o_segment_override_index=0 (last wins), o_segment_override=1.
REQ-040 HOLD with i_flush=1 and i_prefix_ready=1 in the same cycle -> next cycle valid=0, accumulators cleared, pop=0 during the flush cycle.
REQ-041 Reset asserted mid-SCAN after a pop of 3 -> all outputs 0 immediately; the first SCAN after reset release with valid=0 -> pop=0.
